imem_arbiter: RTL and testbench

//  Shares the single-port instruction ROM/RAM between two requesters: the core's fetch port
//  (read-only) and a program loader/debug port (read/write). Sits between mips core, loader
//  and instruction memory in cpu top; owns all memory-enable/address sequencing and the

---
 rtl/imem_arb_pkg.sv | 31 +++
 rtl/imem_arb_pick.sv | 37 +++
 rtl/imem_arbiter.sv | 158 +++++++++++++++
 tb/tb_imem_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Holds the FSM state and access-owner enums plus the legal memory-latency range.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LDR   = 1'b1
    } owner_t;

    localparam int REQ_FETCH   = 0;
    localparam int REQ_LDR     = 1;
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    // Counter preload for a given latency, clamped so an out-of-range parameter still
    // yields a well-formed access.
    function automatic logic [3:0] lat_load(input int lat);
        int l;
        l = lat;
        if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
        if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
        return 4'(l - 1);
    endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Two-way request picker producing a one-hot grant (bit 0 fetch, bit 1 loader).
// ARB_RR_EN selects round-robin on contention; otherwise the loader always wins.
module imem_arb_pick
    import imem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

`ifdef ARB_RR_EN
    // prio set means the loader is favoured on the next contended cycle.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end else if (req[REQ_LDR]) begin
            gnt = 2'b10;
        end else if (req[REQ_FETCH]) begin
            gnt = 2'b01;
        end
    end
`else
    logic unused_prio;
    assign unused_prio = prio;

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_LDR]) begin
            gnt = 2'b10;
        end else if (req[REQ_FETCH]) begin
            gnt = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction memory between the core fetch port and the loader port.
// One access in flight: IDLE -> ACCESS (MEM_LAT cycles) -> RESP. Define ARB_RR_EN for round-robin.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [DW-1:0] fetch_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] LAT_LOAD = lat_load(MEM_LAT);

    state_t        state;
    state_t        state_nxt;
    owner_t        owner_q;
    owner_t        rr_ptr;
    logic          we_q;
    logic [AW-3:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    cnt_q;
    logic [DW-1:0] fetch_rdata_q;
    logic [DW-1:0] ldr_rdata_q;
    logic [1:0]    req;
    logic [1:0]    pick;
    logic          accept;
    logic          last_beat;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{fetch_addr[1:0], ldr_addr[1:0]};

    assign req       = {ldr_req, fetch_req};
    assign accept    = (state == IDLE) && (|pick);
    assign last_beat = (cnt_q == 4'd0);

    imem_arb_pick u_pick (
        .req  (req),
        .prio (rr_ptr == OWN_LDR),
        .gnt  (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pick) state_nxt = ACCESS;
            ACCESS:  if (last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured at grant so later changes on the ports cannot disturb
    // the access; the RR pointer always favours the port that was not just served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_FETCH;
            rr_ptr  <= OWN_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
        end else if (accept) begin
            if (pick[REQ_LDR]) begin
                owner_q <= OWN_LDR;
                rr_ptr  <= OWN_FETCH;
                we_q    <= ldr_we;
                addr_q  <= ldr_addr[AW-1:2];
                wdata_q <= ldr_wdata;
            end else begin
                owner_q <= OWN_FETCH;
                rr_ptr  <= OWN_LDR;
                we_q    <= 1'b0;
                addr_q  <= fetch_addr[AW-1:2];
                wdata_q <= '0;
            end
            cnt_q <= LAT_LOAD;
        end else if (state == ACCESS && !last_beat) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Read data lands on the final access cycle; a loader write reports zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_rdata_q <= '0;
            ldr_rdata_q   <= '0;
        end else if (state == ACCESS && last_beat) begin
            if (owner_q == OWN_LDR) begin
                ldr_rdata_q <= we_q ? '0 : mem_rdata;
            end else begin
                fetch_rdata_q <= mem_rdata;
            end
        end
    end

    // Grants are masked while reset is asserted so every output reads zero in reset.
    always_comb begin
        fetch_gnt    = 1'b0;
        ldr_gnt      = 1'b0;
        fetch_rvalid = 1'b0;
        ldr_rvalid   = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                fetch_gnt = pick[REQ_FETCH] & rst;
                ldr_gnt   = pick[REQ_LDR] & rst;
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q && (owner_q == OWN_LDR);
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                fetch_rvalid = (owner_q == OWN_FETCH);
                ldr_rvalid   = (owner_q == OWN_LDR);
            end
            default: busy = 1'b0;
        endcase
    end

    assign fetch_rdata = fetch_rdata_q;
    assign ldr_rdata   = ldr_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus random traffic against a
// timeline-based reference model. Expectations follow ARB_RR_EN when it is defined.
module tb_imem_arbiter;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        ldr_req;
    logic        ldr_we;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_cmp;
    int n_fail;

    // requester intent, applied to the pins once per cycle
    bit          f_req, l_req, l_we, hold_req;
    logic [31:0] f_addr, l_addr, l_wdata;

    // reference model: one access in flight, described by its grant cycle
    int          cyc, next_free, acc_start;
    bit          acc_live, acc_ldr, acc_we, rr_ldr;
    logic [29:0] acc_waddr;
    logic [31:0] acc_wdata, acc_val;
    logic [31:0] ref_mem [16];
    bit          exp_fgnt, exp_lgnt, exp_busy, exp_en, exp_we, exp_frv, exp_lrv;
    logic [31:0] exp_frd, exp_lrd;

    logic [31:0] phys [16];

    imem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .ldr_req      (ldr_req),
        .ldr_we       (ldr_we),
        .ldr_addr     (ldr_addr),
        .ldr_wdata    (ldr_wdata),
        .ldr_gnt      (ldr_gnt),
        .ldr_rvalid   (ldr_rvalid),
        .ldr_rdata    (ldr_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h2001_0005 : (32'hA500_0000 | 32'(i * 7 + 1));
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // asynchronous-read memory behind the arbiter
    assign mem_rdata = phys[mem_addr[3:0]];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) phys[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            phys[mem_addr[3:0]] <= mem_wdata;
        end
    end

    task automatic model_reset();
        cyc = 0; next_free = 0; acc_live = 0; rr_ldr = 0;
        exp_frd = '0; exp_lrd = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    // Evaluates the model for the current cycle from the values on the request pins.
    task automatic model_step();
        exp_busy = (cyc < next_free);
        exp_fgnt = 0;
        exp_lgnt = 0;
        if (!exp_busy && (f_req || l_req)) begin
            if (f_req && l_req) begin
`ifdef ARB_RR_EN
                acc_ldr = rr_ldr;
`else
                acc_ldr = 1'b1;
`endif
            end else begin
                acc_ldr = l_req;
            end
            exp_fgnt  = !acc_ldr;
            exp_lgnt  = acc_ldr;
            acc_we    = acc_ldr && l_we;
            acc_waddr = acc_ldr ? 30'(l_addr >> 2) : 30'(f_addr >> 2);
            acc_wdata = l_wdata;
            if (acc_we) ref_mem[acc_waddr[3:0]] = l_wdata;
            acc_val   = acc_we ? 32'h0 : ref_mem[acc_waddr[3:0]];
            acc_start = cyc;
            acc_live  = 1;
            next_free = cyc + LAT + 2;
            rr_ldr    = !acc_ldr;
        end
        exp_en  = acc_live && (cyc > acc_start) && (cyc <= acc_start + LAT);
        exp_we  = exp_en && acc_we;
        exp_frv = acc_live && (cyc == acc_start + LAT + 1) && !acc_ldr;
        exp_lrv = acc_live && (cyc == acc_start + LAT + 1) && acc_ldr;
        if (exp_frv) exp_frd = acc_val;
        if (exp_lrv) exp_lrd = acc_val;
        cyc++;
    endtask

    // Drives one cycle of requests just after the edge; returns at the following negedge.
    task automatic cycle();
        @(posedge clk);
        #1;
        fetch_req  = f_req;
        fetch_addr = f_addr;
        ldr_req    = l_req;
        ldr_we     = l_we;
        ldr_addr   = l_addr;
        ldr_wdata  = l_wdata;
        model_step();
        @(negedge clk);
        if (!hold_req) begin
            if (exp_fgnt) f_req = 0;
            if (exp_lgnt) l_req = 0;
        end
    endtask

    task automatic do_reset();
        rst = 0;
        f_req = 0; l_req = 0; l_we = 0; hold_req = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        fetch_req = 0; ldr_req = 0; ldr_we = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 0;
        fetch_req = 1; fetch_addr = 32'h10;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h8; ldr_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({fetch_gnt, ldr_gnt, fetch_rvalid, ldr_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b want 0000000",
                     {fetch_gnt, ldr_gnt, fetch_rvalid, ldr_rvalid, mem_en, mem_we, busy});
        end
        n_cmp++;
        if (mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if (fetch_rdata !== 32'h0 || ldr_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_rdata: got %h/%h want 0", fetch_rdata, ldr_rdata);
        end
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        f_req = 1; f_addr = 32'h0000_0010;
        for (int k = 0; k <= LAT + 2; k++) begin
            cycle();
            n_cmp++;
            if (fetch_gnt !== (k == 0)) begin
                n_fail++;
                $display("[TB] FAIL fetch_gnt k=%0d: got %b want %b", k, fetch_gnt, k == 0);
            end
            n_cmp++;
            if (mem_en !== (k >= 1 && k <= LAT) || (mem_en === 1'b1 && mem_addr !== 30'h4)) begin
                n_fail++;
                $display("[TB] FAIL fetch_mem k=%0d: got en %b addr %h want en %b addr 4",
                         k, mem_en, mem_addr, (k >= 1 && k <= LAT));
            end
            n_cmp++;
            if (fetch_rvalid !== (k == LAT + 1)) begin
                n_fail++;
                $display("[TB] FAIL fetch_rvalid k=%0d: got %b want %b", k, fetch_rvalid, k == LAT + 1);
            end
            if (k == LAT + 1) begin
                n_cmp++;
                if (fetch_rdata !== 32'h2001_0005) begin
                    n_fail++;
                    $display("[TB] FAIL fetch_rdata: got %h want 20010005", fetch_rdata);
                end
            end
        end
    endtask

    task automatic test_loader_write();
        int we_cycles;
        do_reset();
        l_req = 1; l_we = 0; l_addr = 32'h10;
        for (int k = 0; k <= LAT + 1; k++) cycle();
        n_cmp++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== 32'h2001_0005) begin
            n_fail++;
            $display("[TB] FAIL ldr_read: got rvalid %b rdata %h want 1 20010005", ldr_rvalid, ldr_rdata);
        end
        cycle();
        l_req = 1; l_we = 1; l_addr = 32'h8; l_wdata = 32'hDEAD_BEEF;
        we_cycles = 0;
        for (int k = 0; k <= LAT + 1; k++) begin
            cycle();
            if (mem_we === 1'b1) we_cycles++;
            if (k >= 1 && k <= LAT) begin
                n_cmp++;
                if (mem_we !== 1'b1 || mem_addr !== 30'h2 || mem_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("[TB] FAIL ldr_write_beat k=%0d: got we %b addr %h wdata %h want 1 2 deadbeef",
                             k, mem_we, mem_addr, mem_wdata);
                end
            end
        end
        n_cmp++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL ldr_write_done: got rvalid %b rdata %h want 1 0", ldr_rvalid, ldr_rdata);
        end
        n_cmp++;
        if (we_cycles !== LAT) begin
            n_fail++;
            $display("[TB] FAIL ldr_we_count: got %0d want %0d", we_cycles, LAT);
        end
        l_we = 0;
        f_req = 1; f_addr = 32'h8;
        for (int k = 0; k <= LAT + 2; k++) begin
            cycle();
            n_cmp++;
            if (mem_we !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL fetch_no_we k=%0d: got %b want 0", k, mem_we);
            end
        end
        n_cmp++;
        if (fetch_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("[TB] FAIL readback: got %h want deadbeef", fetch_rdata);
        end
    endtask

    task automatic test_contention();
        bit seq [$];
        int fgnt_seen;
        do_reset();
        hold_req = 1;
        f_req = 1; f_addr = 32'h4;
        l_req = 1; l_we = 0; l_addr = 32'hC;
        fgnt_seen = 0;
        for (int k = 0; k < 4 * (LAT + 2); k++) begin
            cycle();
            n_cmp++;
            if ({fetch_gnt, ldr_gnt} !== {exp_fgnt, exp_lgnt}) begin
                n_fail++;
                $display("[TB] FAIL contention_gnt k=%0d: got %b want %b", k,
                         {fetch_gnt, ldr_gnt}, {exp_fgnt, exp_lgnt});
            end
            if (fetch_gnt === 1'b1) fgnt_seen++;
            if (seq.size() < 4) begin
                if (fetch_gnt === 1'b1) seq.push_back(1'b0);
                else if (ldr_gnt === 1'b1) seq.push_back(1'b1);
            end
        end
        n_cmp++;
        if (seq.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL contention_count: got %0d grants want 4", seq.size());
        end
        for (int i = 0; i < seq.size(); i++) begin
            n_cmp++;
`ifdef ARB_RR_EN
            if (seq[i] !== 1'(i % 2)) begin
                n_fail++;
                $display("[TB] FAIL rr_order[%0d]: got %s want %s", i,
                         seq[i] ? "L" : "F", (i % 2) ? "L" : "F");
            end
`else
            if (seq[i] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL fixed_order[%0d]: got %s want L", i, seq[i] ? "L" : "F");
            end
`endif
        end
`ifndef ARB_RR_EN
        n_cmp++;
        if (fgnt_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL fetch_starved: got %0d fetch grants want 0", fgnt_seen);
        end
`endif
        hold_req = 0; f_req = 0; l_req = 0;
        for (int k = 0; k < LAT + 2; k++) cycle();
    endtask

    task automatic test_back_to_back();
        int gq [$];
        int en_count, ngnt;
        do_reset();
        hold_req = 1;
        f_req = 1; f_addr = 32'h0;
        en_count = 0; ngnt = 0;
        for (int k = 0; k < 3 * (LAT + 2); k++) begin
            cycle();
            if (fetch_gnt === 1'b1) gq.push_back(k);
            if (mem_en === 1'b1) begin
                en_count++;
                n_cmp++;
                if (mem_addr !== 30'(k / (LAT + 2))) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_addr k=%0d: got %h want %h", k, mem_addr, k / (LAT + 2));
                end
            end
            n_cmp++;
            if (fetch_rvalid !== exp_frv || fetch_rdata !== exp_frd) begin
                n_fail++;
                $display("[TB] FAIL b2b_resp k=%0d: got %b %h want %b %h", k,
                         fetch_rvalid, fetch_rdata, exp_frv, exp_frd);
            end
            if (exp_fgnt) begin
                ngnt++;
                f_addr = f_addr + 32'h4;
                if (ngnt == 3) f_req = 0;
            end
        end
        hold_req = 0;
        n_cmp++;
        if (gq.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL b2b_gnts: got %0d want 3", gq.size());
        end
        for (int i = 1; i < gq.size(); i++) begin
            n_cmp++;
            if (gq[i] - gq[i-1] != LAT + 2) begin
                n_fail++;
                $display("[TB] FAIL b2b_spacing: got %0d want %0d", gq[i] - gq[i-1], LAT + 2);
            end
        end
        n_cmp++;
        if (en_count != 3 * LAT) begin
            n_fail++;
            $display("[TB] FAIL b2b_en_cycles: got %0d want %0d", en_count, 3 * LAT);
        end
    endtask

    task automatic test_pulse_while_busy();
        int en_count, fg;
        do_reset();
        l_req = 1; l_we = 0; l_addr = 32'h20;
        en_count = 0; fg = 0;
        for (int k = 0; k < LAT + 6; k++) begin
            if (k == 1) begin
                f_req = 1; f_addr = 32'h24;
            end
            cycle();
            if (k == 1) f_req = 0;
            if (fetch_gnt === 1'b1) fg++;
            if (mem_en === 1'b1) en_count++;
            n_cmp++;
            if ({fetch_gnt, ldr_gnt, mem_en, busy} !== {exp_fgnt, exp_lgnt, exp_en, exp_busy}) begin
                n_fail++;
                $display("[TB] FAIL pulse k=%0d: got %b want %b", k,
                         {fetch_gnt, ldr_gnt, mem_en, busy}, {exp_fgnt, exp_lgnt, exp_en, exp_busy});
            end
        end
        n_cmp++;
        if (fg != 0 || en_count != LAT) begin
            n_fail++;
            $display("[TB] FAIL pulse_effect: got %0d fetch gnts %0d en cycles want 0 %0d", fg, en_count, LAT);
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        f_req = 1; f_addr = 32'h14;
        cycle();
        cycle();
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        n_cmp++;
        if ({mem_en, busy, fetch_rvalid} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got en/busy/rvalid %b want 000", {mem_en, busy, fetch_rvalid});
        end
        f_req = 0; fetch_req = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        model_reset();
        for (int k = 0; k < LAT + 4; k++) begin
            cycle();
            n_cmp++;
            if ({fetch_rvalid, mem_en} !== 2'b00 || fetch_rdata !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL after_reset k=%0d: got rvalid %b en %b rdata %h want 0 0 0",
                         k, fetch_rvalid, mem_en, fetch_rdata);
            end
        end
    endtask

    task automatic test_random_traffic();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (!f_req && $urandom_range(0, 3) == 0) begin
                f_req = 1; f_addr = $urandom_range(0, 63);
            end else if (f_req && $urandom_range(0, 15) == 0) begin
                f_req = 0;
            end
            if (!l_req && $urandom_range(0, 4) == 0) begin
                l_req = 1; l_we = 1'($urandom_range(0, 1));
                l_addr = $urandom_range(0, 63); l_wdata = $urandom;
            end
            cycle();
            n_cmp++;
            if ({fetch_gnt, ldr_gnt, fetch_rvalid, ldr_rvalid, mem_en, mem_we, busy} !==
                {exp_fgnt, exp_lgnt, exp_frv, exp_lrv, exp_en, exp_we, exp_busy}) begin
                n_fail++;
                $display("[TB] FAIL rand_ctrl k=%0d: got %b want %b", k,
                         {fetch_gnt, ldr_gnt, fetch_rvalid, ldr_rvalid, mem_en, mem_we, busy},
                         {exp_fgnt, exp_lgnt, exp_frv, exp_lrv, exp_en, exp_we, exp_busy});
            end
            n_cmp++;
            if (fetch_rdata !== exp_frd || ldr_rdata !== exp_lrd) begin
                n_fail++;
                $display("[TB] FAIL rand_rdata k=%0d: got %h/%h want %h/%h", k,
                         fetch_rdata, ldr_rdata, exp_frd, exp_lrd);
            end
            if (exp_en) begin
                n_cmp++;
                if (mem_addr !== acc_waddr || (exp_we && mem_wdata !== acc_wdata)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_mem k=%0d: got %h %h want %h %h", k,
                             mem_addr, mem_wdata, acc_waddr, acc_wdata);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 0;
        fetch_req = 0; fetch_addr = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        f_req = 0; l_req = 0; l_we = 0; hold_req = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        model_reset();
        test_reset();
        test_single_fetch();
        test_loader_write();
        test_contention();
        test_back_to_back();
        test_pulse_while_busy();
        test_reset_mid_access();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
